// File: rtl/mcu_spi_rx.sv
// MCU-side SPI mode-0 receiver: synchronizes the MCU pins, decodes a 6-byte header
// into one PSRAM command and buffers write payload in a small byte FIFO.
module mcu_spi_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MCU_SCLK,
    input  logic              MCU_CS,
    input  logic              MCU_MOSI,
    input  logic              MCU_REQ,
    output logic              MCU_ACK,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       cmd_len,
    output logic [7:0]        wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              frame_err
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ISSUE, S_DATA, S_ERR, S_WAIT_CS
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       len;
    } cmd_t;

    state_t      state, state_nx;
    cmd_t        cmd_q;

    logic [2:0]  sclk_sync, cs_sync;
    logic [1:0]  mosi_sync, req_sync;
    logic        sclk_rise, cs_s, cs_rise, mosi_s, req_s;

    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q, byte_q;
    logic        byte_done;

    logic [2:0]  hdr_cnt;
    logic        hdr_write;
    logic [ADDR_W-1:0] hdr_addr;
    logic [7:0]  hdr_len;
    logic [15:0] pay_cnt;
    logic        op_ok, in_payload;
    logic        push_c, pay_err, err_c, issue_c;
    logic        push_q;
    logic [7:0]  push_byte;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0] count;
    logic        fifo_full, fifo_empty, push_ok, pop_ok;

    // CS sync resets to "asserted" so a frame in progress at reset is waited out.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b000;
            mosi_sync <= 2'b00;
            req_sync  <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], MCU_SCLK};
            cs_sync   <= {cs_sync[1:0], MCU_CS};
            mosi_sync <= {mosi_sync[0], MCU_MOSI};
            req_sync  <= {req_sync[0], MCU_REQ};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign cs_s      = cs_sync[1];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign mosi_s    = mosi_sync[1];
    assign req_s     = req_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shift_q <= {shift_q[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_q    <= {shift_q[6:0], mosi_s};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_WAIT_CS;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (!cs_s) state_nx = S_HDR;
            S_HDR: begin
                if (cs_s)                                     state_nx = S_IDLE;
                else if (byte_done && hdr_cnt == 3'd0 && !op_ok) state_nx = S_ERR;
                else if (issue_c)                             state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (pay_err)                     state_nx = S_ERR;
                else if (cmd_valid && cmd_ready) state_nx = S_DATA;
            end
            S_DATA: begin
                if (cs_s)         state_nx = S_IDLE;
                else if (pay_err) state_nx = S_ERR;
            end
            S_ERR, S_WAIT_CS: if (cs_s) state_nx = S_IDLE;
            default:          state_nx = S_WAIT_CS;
        endcase
    end

    // Payload is accepted in ISSUE as well, so bytes arriving before cmd_ready are kept.
    always_comb begin
        op_ok      = (byte_q == 8'h02) || (byte_q == 8'h03);
        in_payload = (state == S_ISSUE || state == S_DATA) && cmd_q.write && byte_done && !cs_s;
        pay_err    = in_payload && (pay_cnt == cmd_q.len || fifo_full);
        push_c     = in_payload && !pay_err;
        issue_c    = (state == S_HDR) && !cs_s && byte_done && hdr_cnt == 3'd5;
        err_c      = pay_err;
        if (state == S_HDR && (cs_s || (byte_done && hdr_cnt == 3'd0 && !op_ok)))
            err_c = 1'b1;
        if ((state == S_ISSUE || state == S_DATA) && cs_rise && cmd_q.write && pay_cnt != cmd_q.len)
            err_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt   <= 3'd0;
            hdr_write <= 1'b0;
            hdr_addr  <= '0;
            hdr_len   <= 8'h00;
            cmd_q     <= '0;
            cmd_valid <= 1'b0;
            pay_cnt   <= 16'd0;
            push_q    <= 1'b0;
            push_byte <= 8'h00;
            frame_err <= 1'b0;
            MCU_ACK   <= 1'b0;
        end else begin
            frame_err <= err_c;
            push_q    <= push_c;
            push_byte <= byte_q;
            MCU_ACK   <= (state == S_IDLE) && req_s && cs_s && fifo_empty && !push_q && !cmd_valid;
            if (state == S_IDLE) begin
                hdr_cnt <= 3'd0;
                pay_cnt <= 16'd0;
            end
            if (state == S_HDR && byte_done) begin
                hdr_cnt <= hdr_cnt + 3'd1;
                case (hdr_cnt)
                    3'd0:             hdr_write <= (byte_q == 8'h02);
                    3'd1, 3'd2, 3'd3: hdr_addr  <= {hdr_addr[ADDR_W-9:0], byte_q};
                    3'd4:             hdr_len   <= byte_q;
                    default:          ;
                endcase
            end
            if (issue_c) begin
                cmd_q     <= {hdr_write, hdr_addr, hdr_len, byte_q};
                cmd_valid <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (push_c) pay_cnt <= pay_cnt + 16'd1;
        end
    end

    assign cmd_write = cmd_q.write;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_len   = cmd_q.len;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_ok    = push_q && !fifo_full;
    assign pop_ok     = wr_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign wr_valid = !fifo_empty;
    assign wr_data  = wr_valid ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_mcu_spi_rx.sv
// Directed bench for mcu_spi_rx: bit-bangs SPI frames and checks decode, FIFO and errors.
module tb_mcu_spi_rx;
    logic        clk = 1'b0, reset = 1'b1;
    logic        MCU_SCLK = 1'b0, MCU_CS = 1'b1, MCU_MOSI = 1'b0, MCU_REQ = 1'b0;
    logic        cmd_ready = 1'b0, wr_ready = 1'b0;
    logic        MCU_ACK, cmd_valid, cmd_write, wr_valid, frame_err;
    logic [22:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [7:0]  wr_data;

    mcu_spi_rx #(.FIFO_DEPTH(16), .ADDR_W(23)) dut (
        .clk(clk), .reset(reset), .MCU_SCLK(MCU_SCLK), .MCU_CS(MCU_CS),
        .MCU_MOSI(MCU_MOSI), .MCU_REQ(MCU_REQ), .MCU_ACK(MCU_ACK),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n_cmd, n_err, n_unstable;
    logic        c_write;
    logic [22:0] c_addr;
    logic [15:0] c_len;
    logic [7:0]  got[$];
    logic        p_hold = 1'b0;
    logic [39:0] p_cmd;

    // Observe handshakes away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold && cmd_valid && {cmd_write, cmd_addr, cmd_len} !== p_cmd) n_unstable++;
            p_hold = cmd_valid && !cmd_ready;
            p_cmd  = {cmd_write, cmd_addr, cmd_len};
            if (cmd_valid && cmd_ready) begin
                n_cmd++; c_write = cmd_write; c_addr = cmd_addr; c_len = cmd_len;
            end
            if (wr_valid && wr_ready) got.push_back(wr_data);
            if (frame_err) n_err++;
        end
    end

    task automatic clr();
        n_cmd = 0; n_err = 0; n_unstable = 0; got.delete();
    endtask

    task automatic set_ready(input logic cr, input logic wr);
        @(posedge clk); #1;
        cmd_ready = cr; wr_ready = wr;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            MCU_MOSI = b[i];
            #80 MCU_SCLK = 1'b1;
            #80 MCU_SCLK = 1'b0;
        end
    endtask

    task automatic spi_bytes(input logic [7:0] q[$]);
        foreach (q[i]) spi_byte(q[i]);
    endtask

    task automatic cs_low();
        MCU_CS = 1'b0; #80;
    endtask

    task automatic cs_high();
        #80 MCU_CS = 1'b1; #300;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (MCU_ACK !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0h exp=0", MCU_ACK); end
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%0h exp=0", cmd_valid); end
        checks++; if (cmd_write !== 1'b0) begin failures++; $display("FAIL reset_cmd_write got=%0h exp=0", cmd_write); end
        checks++; if (cmd_addr !== 23'h0) begin failures++; $display("FAIL reset_cmd_addr got=%0h exp=0", cmd_addr); end
        checks++; if (cmd_len !== 16'h0) begin failures++; $display("FAIL reset_cmd_len got=%0h exp=0", cmd_len); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%0h exp=0", wr_valid); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0h exp=0", frame_err); end
        MCU_REQ = 1'b1;
        #200;
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL reset_ack_req got=%0h exp=1", MCU_ACK); end
    endtask

    task automatic test_write();
        clr();
        set_ready(1'b1, 1'b1);
        cs_low();
        checks++; if (MCU_ACK !== 1'b0) begin failures++; $display("FAIL write_ack_drop got=%0h exp=0", MCU_ACK); end
        spi_bytes('{8'h02, 8'h12, 8'h34, 8'h56, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        cs_high();
        checks++; if (n_cmd !== 1) begin failures++; $display("FAIL write_ncmd got=%0d exp=1", n_cmd); end
        checks++; if (c_write !== 1'b1) begin failures++; $display("FAIL write_cmd_write got=%0h exp=1", c_write); end
        checks++; if (c_addr !== 23'h123456) begin failures++; $display("FAIL write_addr got=%0h exp=123456", c_addr); end
        checks++; if (c_len !== 16'd3) begin failures++; $display("FAIL write_len got=%0h exp=3", c_len); end
        checks++; if (got.size() !== 3) begin failures++; $display("FAIL write_count got=%0d exp=3", got.size()); end
        else begin
            checks++; if ({got[0], got[1], got[2]} !== 24'hAABBCC) begin
                failures++; $display("FAIL write_data got=%h%h%h exp=aabbcc", got[0], got[1], got[2]); end
        end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL write_err got=%0d exp=0", n_err); end
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL write_ack_back got=%0h exp=1", MCU_ACK); end
    endtask

    task automatic test_read();
        clr();
        cs_low();
        spi_bytes('{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        cs_high();
        checks++; if (n_cmd !== 1) begin failures++; $display("FAIL read_ncmd got=%0d exp=1", n_cmd); end
        checks++; if (c_write !== 1'b0) begin failures++; $display("FAIL read_cmd_write got=%0h exp=0", c_write); end
        checks++; if (c_addr !== 23'h7FFFFF) begin failures++; $display("FAIL read_addr got=%0h exp=7fffff", c_addr); end
        checks++; if (c_len !== 16'h0100) begin failures++; $display("FAIL read_len got=%0h exp=100", c_len); end
        checks++; if (got.size() !== 0) begin failures++; $display("FAIL read_fifo got=%0d exp=0", got.size()); end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL read_err got=%0d exp=0", n_err); end
    endtask

    task automatic test_bad_opcode();
        clr();
        cs_low();
        spi_bytes('{8'h05, 8'h12, 8'h34});
        cs_high();
        checks++; if (n_err !== 1) begin failures++; $display("FAIL badop_err got=%0d exp=1", n_err); end
        checks++; if (n_cmd !== 0 || cmd_valid !== 1'b0) begin
            failures++; $display("FAIL badop_cmd got=%0d/%0h exp=0/0", n_cmd, cmd_valid); end
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL badop_ack got=%0h exp=1", MCU_ACK); end
    endtask

    task automatic test_short_header();
        clr();
        cs_low();
        spi_bytes('{8'h02, 8'h12, 8'h34});
        cs_high();
        checks++; if (n_err !== 1) begin failures++; $display("FAIL shorthdr_err got=%0d exp=1", n_err); end
        checks++; if (n_cmd !== 0 || cmd_valid !== 1'b0) begin
            failures++; $display("FAIL shorthdr_cmd got=%0d/%0h exp=0/0", n_cmd, cmd_valid); end
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL shorthdr_ack got=%0h exp=1", MCU_ACK); end
    endtask

    task automatic test_overflow();
        int bad;
        clr();
        set_ready(1'b1, 1'b0);
        cs_low();
        spi_bytes('{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h14});
        for (int i = 0; i < 17; i++) spi_byte(8'h40 + 8'(i));
        cs_high();
        checks++; if (n_err !== 1) begin failures++; $display("FAIL ovf_err got=%0d exp=1", n_err); end
        checks++; if (n_cmd !== 1) begin failures++; $display("FAIL ovf_ncmd got=%0d exp=1", n_cmd); end
        checks++; if (MCU_ACK !== 1'b0) begin failures++; $display("FAIL ovf_ack_full got=%0h exp=0", MCU_ACK); end
        set_ready(1'b1, 1'b1);
        #500;
        checks++; if (got.size() !== 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", got.size()); end
        else begin
            bad = 0;
            foreach (got[i]) if (got[i] !== 8'h40 + 8'(i)) bad++;
            checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_order got=%0d wrong exp=0", bad); end
        end
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL ovf_ack_drained got=%0h exp=1", MCU_ACK); end
    endtask

    task automatic test_cmd_stall();
        clr();
        set_ready(1'b0, 1'b0);
        cs_low();
        spi_bytes('{8'h02, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h02, 8'h11, 8'h22});
        cs_high();
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0h exp=1", cmd_valid); end
        checks++; if ({cmd_write, cmd_addr, cmd_len} !== {1'b1, 23'h00ABCD, 16'd2}) begin
            failures++; $display("FAIL stall_fields got=%0h/%0h/%0h exp=1/abcd/2", cmd_write, cmd_addr, cmd_len); end
        checks++; if (wr_valid !== 1'b1 || wr_data !== 8'h11) begin
            failures++; $display("FAIL stall_buffered got=%0h/%0h exp=1/11", wr_valid, wr_data); end
        checks++; if (MCU_ACK !== 1'b0) begin failures++; $display("FAIL stall_ack got=%0h exp=0", MCU_ACK); end
        set_ready(1'b1, 1'b0);
        #100;
        checks++; if (n_cmd !== 1 || cmd_valid !== 1'b0) begin
            failures++; $display("FAIL stall_taken got=%0d/%0h exp=1/0", n_cmd, cmd_valid); end
        checks++; if (MCU_ACK !== 1'b0) begin failures++; $display("FAIL stall_ack_fifo got=%0h exp=0", MCU_ACK); end
        set_ready(1'b0, 1'b1);
        #200;
        checks++; if (got.size() !== 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", got.size()); end
        else begin
            checks++; if ({got[0], got[1]} !== 16'h1122) begin
                failures++; $display("FAIL stall_data got=%h%h exp=1122", got[0], got[1]); end
        end
        checks++; if (n_unstable !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", n_unstable); end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL stall_err got=%0d exp=0", n_err); end
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL stall_ack_back got=%0h exp=1", MCU_ACK); end
    endtask

    task automatic test_reset_midframe();
        clr();
        set_ready(1'b1, 1'b1);
        cs_low();
        spi_bytes('{8'h02, 8'h12});
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if ({MCU_ACK, cmd_valid, wr_valid, frame_err} !== 4'b0) begin
            failures++; $display("FAIL rst_mid_flags got=%b exp=0000", {MCU_ACK, cmd_valid, wr_valid, frame_err}); end
        checks++; if ({cmd_write, cmd_addr, cmd_len} !== 40'h0) begin
            failures++; $display("FAIL rst_mid_cmd got=%0h exp=0", {cmd_write, cmd_addr, cmd_len}); end
        spi_bytes('{8'h34, 8'h56, 8'h00, 8'h01, 8'hEE});
        cs_high();
        checks++; if (n_cmd !== 0 || got.size() !== 0 || n_err !== 0) begin
            failures++; $display("FAIL rst_mid_ignored got=%0d/%0d/%0d exp=0/0/0", n_cmd, got.size(), n_err); end
        checks++; if (MCU_ACK !== 1'b1) begin failures++; $display("FAIL rst_mid_ack got=%0h exp=1", MCU_ACK); end
        clr();
        cs_low();
        spi_bytes('{8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 8'h5A});
        cs_high();
        checks++; if (n_cmd !== 1 || c_write !== 1'b1 || c_addr !== 23'h10 || c_len !== 16'd1) begin
            failures++; $display("FAIL rst_next_cmd got=%0d/%0h/%0h/%0h exp=1/1/10/1", n_cmd, c_write, c_addr, c_len); end
        checks++; if (got.size() !== 1) begin failures++; $display("FAIL rst_next_count got=%0d exp=1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h5A) begin failures++; $display("FAIL rst_next_data got=%0h exp=5a", got[0]); end
        end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL rst_next_err got=%0d exp=0", n_err); end
    endtask

    initial begin
        clr();
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_short_header();
        test_overflow();
        test_cmd_stall();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
